// File: rtl/memtest_pkg.sv
// Shared types and helpers for the RAM tester.
//   state_e      : tester FSM states
//   WORD_W       : pattern / RAM data width
//   LFSR_TAPS    : Galois mask for x^32+x^22+x^2+x+1 (right-shifting form)
//   lfsr_step    : one Galois LFSR advance
//   pattern_addr : address-derived pattern {a8, ~a8, a8, ~a8} ^ seed
package memtest_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [WORD_W-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_e;

  function automatic logic [WORD_W-1:0] lfsr_step(input logic [WORD_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

  function automatic logic [WORD_W-1:0] pattern_addr(input logic [7:0] a8,
                                                     input logic [WORD_W-1:0] seed);
    return {a8, ~a8, a8, ~a8} ^ seed;
  endfunction

endpackage

// File: rtl/memtest_pattern_gen.sv
// Test pattern source. word_o is the pattern for the address being issued next:
// in LFSR mode it is the current LFSR word (SEED when load_i), in address mode it
// is a pure function of addr_i.
// Ports:
//   clk, reset : clock, async active-high reset
//   load_i     : restart the sequence at SEED (word_o = SEED this cycle)
//   advance_i  : step the sequence after the current word
//   addr_i     : word address the pattern is for (address mode)
//   word_o     : 32-bit pattern word (combinational)
// Build option: MEMTEST_LFSR_PATTERN_EN selects the LFSR pattern.
module memtest_pattern_gen
  import memtest_pkg::*;
#(
  parameter int unsigned        ADDR_W = 10,
  parameter logic [WORD_W-1:0]  SEED   = 32'hA5A5_5A5A
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [WORD_W-1:0] word_o
);

  // Each mode leaves some inputs idle.
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, reset, load_i, advance_i, addr_i};

`ifdef MEMTEST_LFSR_PATTERN_EN
  logic [WORD_W-1:0] lfsr_q, lfsr_d, cur_c;

  // Current word, then the state left for the following address.
  always_comb begin : lfsr_next
    cur_c  = load_i ? SEED : lfsr_q;
    lfsr_d = advance_i ? lfsr_step(cur_c) : cur_c;
  end

  always_ff @(posedge clk or posedge reset) begin : lfsr_reg
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign word_o = cur_c;
`else
  assign word_o = pattern_addr(8'(addr_i), SEED);
`endif

endmodule

// File: rtl/memory_test_hw_ram_tester.sv
// Avalon-MM master that writes a pattern to every RAM word, reads it all back,
// compares and reports pass/fail, mismatch count and first failing address.
// Ports:
//   clk, reset        : clock, async active-high reset (aborts a run)
//   start             : 1-cycle pulse, accepted only in IDLE
//   busy, done, pass  : run status; done is sticky until the next accepted start
//   error_count       : mismatching words (saturates at DEPTH)
//   first_fail_addr   : address of the first mismatch, 0 if none
//   m_*               : Avalon-MM master to the RAM (1-cycle read latency, no waitrequest)
// Build option: MEMTEST_LFSR_PATTERN_EN selects the LFSR pattern instead of the
// address-derived one.
module memory_test_hw_ram_tester
  import memtest_pkg::*;
#(
  parameter int unsigned       DEPTH  = 1024,
  parameter int unsigned       ADDR_W = 10,
  parameter int unsigned       DATA_W = 32,
  parameter logic [WORD_W-1:0] SEED   = 32'hA5A5_5A5A
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   error_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [ADDR_W-1:0] m_address,
  output logic [BE_W-1:0]   m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  output logic              m_clken,
  input  logic [DATA_W-1:0] m_readdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   MAX_ERR   = (ADDR_W + 1)'(DEPTH);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               cs_q, cs_d;
  logic               wr_q, wr_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ADDR_W:0]    err_q, err_d;
  logic [ADDR_W-1:0]  ff_q, ff_d;
  // Compare pipe: expected word and address of the read issued last cycle.
  logic               pv_q, pv_d;
  logic [DATA_W-1:0]  pexp_q, pexp_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;

  logic               addr_last_c;
  logic               gen_load_c, gen_adv_c;
  logic [WORD_W-1:0]  gen_word;
  logic               mism_c;

  assign addr_last_c = (addr_q == LAST_ADDR);
  assign mism_c      = pv_q && (m_readdata != pexp_q);

  memtest_pattern_gen #(
    .ADDR_W (ADDR_W),
    .SEED   (SEED)
  ) u_pattern_gen (
    .clk       (clk),
    .reset     (reset),
    .load_i    (gen_load_c),
    .advance_i (gen_adv_c),
    .addr_i    (addr_d),
    .word_o    (gen_word)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin : fsm_reg
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin : fsm_next
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = WR;
      WR:      if (addr_last_c) state_d = RD;
      RD:      if (addr_last_c) state_d = DRAIN;
      DRAIN:   state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address counter and pattern sequencing; the counter holds at DEPTH-1.
  always_comb begin : addr_ctrl
    addr_d     = addr_q;
    gen_load_c = 1'b0;
    gen_adv_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d     = '0;
          gen_load_c = 1'b1;
          gen_adv_c  = 1'b1;
        end
      end
      WR: begin
        gen_adv_c = 1'b1;
        if (addr_last_c) begin
          addr_d     = '0;
          gen_load_c = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      RD: begin
        if (!addr_last_c) begin
          addr_d    = addr_q + ADDR_W'(1);
          gen_adv_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output / datapath next values. The writedata register also carries the
  // expected word of the current read, which is pushed into the compare pipe.
  always_comb begin : fsm_out
    cs_d    = 1'b0;
    wr_d    = 1'b0;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;
    pv_d    = 1'b0;
    pexp_d  = pexp_q;
    paddr_d = paddr_q;

    if (mism_c) begin
      if (err_q == '0)     ff_d  = paddr_q;
      if (err_q != MAX_ERR) err_d = err_q + (ADDR_W + 1)'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          ff_d    = '0;
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          wdata_d = gen_word;
        end
      end
      WR: begin
        cs_d    = 1'b1;
        wr_d    = !addr_last_c;
        wdata_d = gen_word;
      end
      RD: begin
        pv_d    = 1'b1;
        pexp_d  = wdata_q;
        paddr_d = addr_q;
        if (!addr_last_c) begin
          cs_d    = 1'b1;
          wdata_d = gen_word;
        end
      end
      DRAIN: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        pass_d = (err_d == '0);
      end
      default: ;
    endcase

    be_d = cs_d ? '1 : '0;
  end

  always_ff @(posedge clk or posedge reset) begin : dp_reg
    if (reset) begin
      addr_q  <= '0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
      pv_q    <= 1'b0;
      pexp_q  <= '0;
      paddr_q <= '0;
    end else begin
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      pv_q    <= pv_d;
      pexp_q  <= pexp_d;
      paddr_q <= paddr_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign error_count     = err_q;
  assign first_fail_addr = ff_q;
  assign m_address       = addr_q;
  assign m_byteenable    = be_q;
  assign m_chipselect    = cs_q;
  assign m_write         = wr_q;
  assign m_writedata     = wdata_q;
  assign m_clken         = 1'b1;

endmodule

// File: tb/tb_memory_test_hw_ram_tester.sv
// Bench for memory_test_hw_ram_tester with a behavioural 1-cycle-latency RAM.
// Read-back corruption is injected through per-word override tables in the RAM.
module tb_memory_test_hw_ram_tester;

`ifdef MEMTEST_LFSR_PATTERN_EN
  localparam int unsigned DEPTH = 16;
`else
  localparam int unsigned DEPTH = 1024;
`endif
  localparam int unsigned ADDR_W  = 10;
  localparam logic [31:0] SEED    = 32'hA5A5_5A5A;
  localparam logic [31:0] POLY    = 32'h8020_0003;
  localparam int          RST_CYC = (DEPTH >= 1024) ? 1500 : DEPTH + DEPTH / 2;
  localparam int          GLITCH  = (DEPTH >= 1024) ? 500 : DEPTH / 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              busy, done, pass;
  logic [ADDR_W:0]   error_count;
  logic [ADDR_W-1:0] first_fail_addr, m_address;
  logic [3:0]        m_byteenable;
  logic              m_chipselect, m_write, m_clken;
  logic [31:0]       m_writedata, m_readdata;

  logic [31:0] mem     [DEPTH];
  logic        cor_en  [DEPTH];
  logic [31:0] cor_val [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  memory_test_hw_ram_tester #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (32),
    .SEED   (SEED)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .error_count     (error_count),
    .first_fail_addr (first_fail_addr),
    .m_address       (m_address),
    .m_byteenable    (m_byteenable),
    .m_chipselect    (m_chipselect),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_clken         (m_clken),
    .m_readdata      (m_readdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: byte-enabled writes, registered reads with optional override.
  always @(posedge clk) begin
    if (m_chipselect && m_write)
      for (int b = 0; b < 4; b++)
        if (m_byteenable[b]) mem[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
    if (m_chipselect && !m_write)
      m_readdata <= cor_en[m_address] ? cor_val[m_address] : mem[m_address];
  end

  // Reference pattern for word address a.
  function automatic logic [31:0] model_pat(input int a);
    logic [31:0] s;
`ifdef MEMTEST_LFSR_PATTERN_EN
    s = SEED;
    for (int k = 0; k < a; k++) s = (s >> 1) ^ (((s & 32'd1) != 0) ? POLY : 32'd0);
`else
    int b;
    b = a % 256;
    s = (32'(b) << 24) | (32'(255 - b) << 16) | (32'(b) << 8) | 32'(255 - b);
    s = s ^ SEED;
`endif
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_cor();
    for (int a = 0; a < int'(DEPTH); a++) begin
      cor_en[a]  = 1'b0;
      cor_val[a] = 32'd0;
    end
  endtask

  // One full run: per-cycle bus checks, then timing and result checks.
  task automatic run_check(input string tag, input int glitch, input int exp_err,
                           input int exp_first, input logic exp_pass);
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 2 * int'(DEPTH) + 2; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (c == 1) check({tag, "/err_clear"}, 64'(error_count), 64'd0);
      if (c <= 2 * int'(DEPTH) + 1) begin
        check({tag, "/busy"}, 64'(busy), 64'd1);
        check({tag, "/done_early"}, 64'(done), 64'd0);
        if (m_clken !== 1'b1) check({tag, "/clken"}, 64'(m_clken), 64'd1);
        if (c <= int'(DEPTH)) begin
          check({tag, "/wr_cs"}, 64'({m_chipselect, m_write, m_byteenable}), 64'h3F);
          check({tag, "/wr_addr"}, 64'(m_address), 64'(c - 1));
          check({tag, "/wr_data"}, 64'(m_writedata), 64'(model_pat(c - 1)));
        end else if (c <= 2 * int'(DEPTH)) begin
          check({tag, "/rd_cs"}, 64'({m_chipselect, m_write, m_byteenable}), 64'h2F);
          check({tag, "/rd_addr"}, 64'(m_address), 64'(c - int'(DEPTH) - 1));
        end else begin
          check({tag, "/drain_cs"}, 64'({m_chipselect, m_byteenable}), 64'd0);
        end
      end else begin
        check({tag, "/done"}, 64'(done), 64'd1);
        check({tag, "/busy_end"}, 64'(busy), 64'd0);
        check({tag, "/pass"}, 64'(pass), 64'(exp_pass));
        check({tag, "/error_count"}, 64'(error_count), 64'(exp_err));
        check({tag, "/first_fail"}, 64'(first_fail_addr), 64'(exp_first));
      end
      start = (c == glitch) ? 1'b1 : 1'b0;
    end
  endtask

  typedef struct {
    int   lo;
    int   hi;
    int   kind;       // 0 none, 1 flip bit 0, 2 force zero
    int   exp_err;
    int   exp_first;
    logic exp_pass;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int exp_cnt, exp_first, n, a, sel;

    vecs[0] = '{0, 0, 0, 0, 0, 1'b1};
    vecs[1] = '{5, 5, 1, 1, 5, 1'b0};
`ifdef MEMTEST_LFSR_PATTERN_EN
    vecs[2] = '{10, 15, 2, 6, 10, 1'b0};
`else
    vecs[2] = '{10, 19, 2, 10, 10, 1'b0};
`endif
    vecs[3] = '{0, 0, 1, 1, 0, 1'b0};
    vecs[4] = '{int'(DEPTH) - 1, int'(DEPTH) - 1, 1, 1, int'(DEPTH) - 1, 1'b0};
    vecs[5] = '{0, int'(DEPTH) - 1, 2, int'(DEPTH), 0, 1'b0};

    clear_cor();
    start = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst/status", 64'({busy, done, pass, m_chipselect, m_write}), 64'd0);
    check("rst/counts", 64'({error_count, first_fail_addr}), 64'd0);
    check("rst/bus", 64'({m_address, m_writedata, m_byteenable}), 64'd0);
    check("rst/clken", 64'(m_clken), 64'd1);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      clear_cor();
      for (int k = vecs[i].lo; k <= vecs[i].hi && vecs[i].kind != 0; k++) begin
        cor_en[k]  = 1'b1;
        cor_val[k] = (vecs[i].kind == 1) ? (model_pat(k) ^ 32'd1) : 32'd0;
      end
      run_check($sformatf("vec%0d", i), -1, vecs[i].exp_err, vecs[i].exp_first,
                vecs[i].exp_pass);
      if (i == 0) begin
`ifdef MEMTEST_LFSR_PATTERN_EN
        check("ram/w0", 64'(mem[0]), 64'h0000_0000_A5A5_5A5A);
        check("ram/w1", 64'(mem[1]), 64'h0000_0000_52D2_AD2D);
        check("ram/w2", 64'(mem[2]), 64'h0000_0000_A949_5695);
`else
        check("ram/w3", 64'(mem[3]), 64'h0000_0000_A659_59A6);
        check("ram/w256", 64'(mem[256]), 64'h0000_0000_A55A_5AA5);
        check("ram/w1023", 64'(mem[1023]), 64'h0000_0000_5AA5_A55A);
`endif
        repeat (5) @(posedge clk);
        #1;
        check("sticky/done", 64'({done, pass}), 64'h3);
      end
    end

    // start pulse mid-run must neither restart nor clear the result
    clear_cor();
    cor_en[5]  = 1'b1;
    cor_val[5] = model_pat(5) ^ 32'd1;
    run_check("glitch", GLITCH, 1, 5, 1'b0);

    // reset mid-run aborts, then a fresh run is clean
    clear_cor();
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (RST_CYC - 1) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort/status", 64'({busy, done, pass, m_chipselect, m_write}), 64'd0);
    check("abort/counts", 64'({error_count, first_fail_addr, m_address}), 64'd0);
    reset = 1'b0;
    run_check("after_abort", -1, 0, 0, 1'b1);

    // randomized read-back corruption against the counting model
    for (int r = 0; r < 3; r++) begin
      clear_cor();
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        a   = $urandom_range(0, int'(DEPTH) - 1);
        sel = $urandom_range(0, 2);
        cor_en[a]  = 1'b1;
        cor_val[a] = (sel == 0) ? (model_pat(a) ^ (32'd1 << $urandom_range(0, 31))) :
                     (sel == 1) ? 32'($urandom) : model_pat(a);
      end
      exp_cnt   = 0;
      exp_first = 0;
      for (int k = int'(DEPTH) - 1; k >= 0; k--)
        if (cor_en[k] && cor_val[k] != model_pat(k)) begin
          exp_cnt++;
          exp_first = k;
        end
      run_check($sformatf("rand%0d", r), -1, exp_cnt, exp_first, exp_cnt == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule
